// File: rtl/controlador_ascensor.sv
// Per-car elevator controller: latches floor requests, serves them in SCAN order,
// and times one-floor travel and door dwell with a shared up-counter.
module controlador_ascensor #(
    parameter int N_PISOS  = 4,
    parameter int PISO_W   = 2,
    parameter int T_VIAJE  = 4,
    parameter int T_PUERTA = 6,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PISOS-1:0] solicitud,
    output logic [PISO_W-1:0]  piso_actual,
    output logic [1:0]         direccion,
    output logic               puertas_abiertas,
    output logic [N_PISOS-1:0] pendientes
);

    // state    | meaning
    // REPOSO   | idle, doors closed, waiting for a request
    // SUBIENDO | travelling up one floor at a time
    // BAJANDO  | travelling down one floor at a time
    // PUERTAS  | doors open at piso_actual, dwell timer running
    typedef enum logic [1:0] {REPOSO, SUBIENDO, BAJANDO, PUERTAS} estado_t;

    localparam logic [CNT_W-1:0]  FIN_VIAJE  = CNT_W'(T_VIAJE - 1);
    localparam logic [CNT_W-1:0]  FIN_PUERTA = CNT_W'(T_PUERTA - 1);
    localparam logic [PISO_W-1:0] PISO_MAX   = PISO_W'(N_PISOS - 1);

    localparam logic [1:0] DIR_NADA  = 2'b00;
    localparam logic [1:0] DIR_SUBE  = 2'b01;
    localparam logic [1:0] DIR_BAJA  = 2'b10;

    estado_t              estado_q, estado_d;
    logic [PISO_W-1:0]    piso_q, piso_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_PISOS-1:0]   pend_q, pend_d;
    logic                 ult_sube_q, ult_sube_d;
    logic [1:0]           dir_q, dir_d;
    logic                 puertas_q, puertas_d;
    logic [N_PISOS-1:0]   pend_eff;

    function automatic logic hay_arriba(input logic [N_PISOS-1:0] v,
                                        input logic [PISO_W-1:0]  p);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (v[i] && (i > int'(p))) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic hay_abajo(input logic [N_PISOS-1:0] v,
                                       input logic [PISO_W-1:0]  p);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (v[i] && (i < int'(p))) r = 1'b1;
        end
        return r;
    endfunction

    // Preferred direction first, then the opposite one, else stay idle.
    function automatic estado_t decidir(input logic [N_PISOS-1:0] v,
                                        input logic [PISO_W-1:0]  p,
                                        input logic               pref_sube);
        estado_t r;
        r = REPOSO;
        if (pref_sube) begin
            if (hay_arriba(v, p))      r = SUBIENDO;
            else if (hay_abajo(v, p))  r = BAJANDO;
        end else begin
            if (hay_abajo(v, p))       r = BAJANDO;
            else if (hay_arriba(v, p)) r = SUBIENDO;
        end
        return r;
    endfunction

    always_comb begin
        pend_eff   = pend_q | solicitud;
        estado_d   = estado_q;
        piso_d     = piso_q;
        cnt_d      = cnt_q;
        ult_sube_d = ult_sube_q;

        case (estado_q)
            REPOSO: begin
                cnt_d = '0;
                if (pend_eff[piso_q]) estado_d = PUERTAS;
                else                  estado_d = decidir(pend_eff, piso_q, ult_sube_q);
            end
            SUBIENDO, BAJANDO: begin
                if (cnt_q >= FIN_VIAJE) begin
                    cnt_d = '0;
                    // Saturate at the shaft ends even though SCAN never asks for it.
                    if (estado_q == SUBIENDO && piso_q != PISO_MAX)
                        piso_d = piso_q + PISO_W'(1);
                    else if (estado_q == BAJANDO && piso_q != '0)
                        piso_d = piso_q - PISO_W'(1);
                    if (pend_eff[piso_d]) estado_d = PUERTAS;
                    else estado_d = decidir(pend_eff, piso_d, estado_q == SUBIENDO);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PUERTAS: begin
                if (solicitud[piso_q]) begin
                    cnt_d = '0;
                end else if (cnt_q >= FIN_PUERTA) begin
                    cnt_d    = '0;
                    estado_d = decidir(pend_eff, piso_q, ult_sube_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: estado_d = REPOSO;
        endcase

        if (estado_d == SUBIENDO) ult_sube_d = 1'b1;
        if (estado_d == BAJANDO)  ult_sube_d = 1'b0;

        pend_d = pend_eff;
        if (estado_d == PUERTAS) pend_d[piso_d] = 1'b0;

        dir_d     = DIR_NADA;
        puertas_d = 1'b0;
        case (estado_d)
            SUBIENDO: dir_d     = DIR_SUBE;
            BAJANDO:  dir_d     = DIR_BAJA;
            PUERTAS:  puertas_d = 1'b1;
            default:  dir_d     = DIR_NADA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= REPOSO;
            piso_q     <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            ult_sube_q <= 1'b1;
            dir_q      <= DIR_NADA;
            puertas_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            piso_q     <= piso_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            ult_sube_q <= ult_sube_d;
            dir_q      <= dir_d;
            puertas_q  <= puertas_d;
        end
    end

    assign piso_actual      = piso_q;
    assign direccion        = dir_q;
    assign puertas_abiertas = puertas_q;
    assign pendientes       = pend_q;

endmodule

// File: tb/tb_controlador_ascensor.sv
// Scoreboard bench: stimulus queues cycle-stamped expected outputs, a negedge
// monitor pops and compares them as the DUT reaches each stamped cycle.
module tb_controlador_ascensor;

    logic       clk;
    logic       rst_n;
    logic [3:0] solicitud;
    logic [1:0] piso_actual;
    logic [1:0] direccion;
    logic       puertas_abiertas;
    logic [3:0] pendientes;

    controlador_ascensor #(
        .N_PISOS(4), .PISO_W(2), .T_VIAJE(4), .T_PUERTA(6), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .solicitud(solicitud),
        .piso_actual(piso_actual),
        .direccion(direccion),
        .puertas_abiertas(puertas_abiertas),
        .pendientes(pendientes)
    );

    typedef struct {
        int         cyc;
        logic [1:0] piso;
        logic [1:0] dir;
        logic       pu;
        logic [3:0] pend;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc_cnt  = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        n_checks++;
        if (direccion == 2'b11) begin
            n_errors++;
            $display("FAIL dir_never_11 cyc=%0d got direccion=%b", cyc_cnt, direccion);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (mon_e.cyc < cyc_cnt) begin
                n_errors++;
                $display("FAIL %s missed cycle %0d (now %0d)", mon_e.name, mon_e.cyc, cyc_cnt);
            end else if ({piso_actual, direccion, puertas_abiertas, pendientes} !==
                         {mon_e.piso, mon_e.dir, mon_e.pu, mon_e.pend}) begin
                n_errors++;
                $display("FAIL %s cyc=%0d got piso=%0d dir=%b pu=%b pend=%b exp piso=%0d dir=%b pu=%b pend=%b",
                         mon_e.name, cyc_cnt, piso_actual, direccion, puertas_abiertas, pendientes,
                         mon_e.piso, mon_e.dir, mon_e.pu, mon_e.pend);
            end
        end
    end

    task automatic expect_at(input int dc, input logic [1:0] p, input logic [1:0] d,
                             input logic pu, input logic [3:0] pe, input string nm);
        exp_t e;
        e.cyc  = cyc_cnt + dc;
        e.piso = p;
        e.dir  = d;
        e.pu   = pu;
        e.pend = pe;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [3:0] v);
        solicitud = v;
        tick(1);
        solicitud = 4'b0000;
    endtask

    initial begin
        rst_n     = 1'b0;
        solicitud = 4'b1111;
        tick(1);
        expect_at(0, 2'd0, 2'b00, 1'b0, 4'b0000, "reset_c0");
        expect_at(1, 2'd0, 2'b00, 1'b0, 4'b0000, "reset_c1");
        expect_at(2, 2'd0, 2'b00, 1'b0, 4'b0000, "reset_c2");
        tick(2);
        rst_n     = 1'b1;
        solicitud = 4'b0000;
        tick(1);

        // Door cycle at floor 0.
        for (int i = 1; i <= 6; i++)
            expect_at(i, 2'd0, 2'b00, 1'b1, 4'b0000, "door0_open");
        expect_at(7, 2'd0, 2'b00, 1'b0, 4'b0000, "door0_closed");
        pulse(4'b0001);
        tick(6);

        // Travel 0 -> 2.
        expect_at(1,  2'd0, 2'b01, 1'b0, 4'b0100, "up_start");
        expect_at(4,  2'd0, 2'b01, 1'b0, 4'b0100, "up_still0");
        expect_at(5,  2'd1, 2'b01, 1'b0, 4'b0100, "up_floor1");
        expect_at(8,  2'd1, 2'b01, 1'b0, 4'b0100, "up_still1");
        expect_at(9,  2'd2, 2'b00, 1'b1, 4'b0000, "arrive2");
        expect_at(14, 2'd2, 2'b00, 1'b1, 4'b0000, "arrive2_open");
        expect_at(15, 2'd2, 2'b00, 1'b0, 4'b0000, "arrive2_closed");
        pulse(4'b0100);
        tick(14);

        // Door extend at floor 2.
        expect_at(5,  2'd2, 2'b00, 1'b1, 4'b0000, "ext_c5");
        expect_at(7,  2'd2, 2'b00, 1'b1, 4'b0000, "ext_c7");
        expect_at(10, 2'd2, 2'b00, 1'b1, 4'b0000, "ext_c10");
        expect_at(11, 2'd2, 2'b00, 1'b0, 4'b0000, "ext_closed");
        pulse(4'b0100);
        tick(3);
        pulse(4'b0100);
        tick(6);

        // Head down and reset mid-travel.
        expect_at(1, 2'd2, 2'b10, 1'b0, 4'b0001, "down_start");
        expect_at(5, 2'd1, 2'b10, 1'b0, 4'b0001, "down_floor1");
        pulse(4'b0001);
        tick(5);
        rst_n = 1'b0;
        expect_at(0, 2'd0, 2'b00, 1'b0, 4'b0000, "reset_mid");
        tick(2);
        rst_n = 1'b1;

        // SCAN: go to 3, pick up 0 on the way back.
        expect_at(1,  2'd0, 2'b01, 1'b0, 4'b1000, "scan_start");
        expect_at(6,  2'd1, 2'b01, 1'b0, 4'b1001, "scan_latch0");
        expect_at(9,  2'd2, 2'b01, 1'b0, 4'b1001, "scan_pass2");
        expect_at(13, 2'd3, 2'b00, 1'b1, 4'b0001, "scan_at3");
        expect_at(18, 2'd3, 2'b00, 1'b1, 4'b0001, "scan_at3_open");
        expect_at(19, 2'd3, 2'b10, 1'b0, 4'b0001, "scan_reverse");
        expect_at(23, 2'd2, 2'b10, 1'b0, 4'b0001, "scan_down2");
        expect_at(31, 2'd0, 2'b00, 1'b1, 4'b0000, "scan_at0");
        expect_at(37, 2'd0, 2'b00, 1'b0, 4'b0000, "scan_idle");
        pulse(4'b1000);
        tick(4);
        pulse(4'b0001);
        tick(31);

        // Simultaneous requests while passing floor 1.
        expect_at(1,  2'd0, 2'b01, 1'b0, 4'b0100, "sim_start");
        expect_at(6,  2'd1, 2'b01, 1'b0, 4'b0101, "sim_latch");
        expect_at(9,  2'd2, 2'b00, 1'b1, 4'b0001, "sim_at2");
        expect_at(15, 2'd2, 2'b10, 1'b0, 4'b0001, "sim_reverse");
        expect_at(19, 2'd1, 2'b10, 1'b0, 4'b0001, "sim_down1");
        expect_at(23, 2'd0, 2'b00, 1'b1, 4'b0000, "sim_at0");
        expect_at(29, 2'd0, 2'b00, 1'b0, 4'b0000, "sim_idle");
        pulse(4'b0100);
        tick(4);
        pulse(4'b0101);
        tick(23);
        tick(2);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d entries left, exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
